// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci/Galois LFSR with seed load, lockup recovery and period measurement
module lfsr_prng #(
    parameter int          WIDTH = 64,
    parameter logic [63:0] TAPS  = 64'd0,
    parameter int          CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             load,
    input  logic             enable,
    input  logic             mode,
    output logic [WIDTH-1:0] seed_out,
    output logic             lockup,
    output logic             repeat_found,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);
    localparam logic [63:0] TBL = (WIDTH == 8)  ? 64'hB8 :
                                  (WIDTH == 16) ? 64'hD008 :
                                  (WIDTH == 32) ? 64'h8020_0003 :
                                  (WIDTH == 64) ? 64'hD800_0000_0000_0000 : 64'h0;
    localparam logic [WIDTH-1:0] MASK = (TAPS != '0) ? TAPS[WIDTH-1:0] : TBL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("lfsr_prng: WIDTH must be 4..64");
    end
    if (TAPS == '0 && TBL == '0) begin : g_no_taps
        $error("lfsr_prng: no built-in tap mask for this WIDTH");
    end
    if (!MASK[WIDTH-1]) begin : g_bad_taps
        $error("lfsr_prng: tap mask must include x^WIDTH");
    end

    logic [WIDTH-1:0] state, ref_q, seed_fix, fib, gal, nxt, ref_eff;
    logic [CNT_W-1:0] cnt, cnt_base, cnt_inc, period_q;
    logic             mode_q, lockup_q, repeat_q, valid_q, zero, mode_chg, hit;

    // A mode flip re-anchors the measurement on the pre-step state
    always_comb begin
        seed_fix = (seed_in == '0) ? ONE : seed_in;
        fib      = {state[WIDTH-2:0], ^(state & MASK)};
        gal      = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? {MASK[WIDTH-2:0], 1'b1} : '0);
        zero     = state == '0;
        nxt      = zero ? ONE : (mode ? gal : fib);
        mode_chg = mode != mode_q;
        ref_eff  = mode_chg ? state : ref_q;
        cnt_base = mode_chg ? '0 : cnt;
        cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + CNT_ONE;
        hit      = nxt == ref_eff;
    end

    always_ff @(posedge clk) begin
        if (reset || load) begin
            state    <= seed_fix;
            ref_q    <= seed_fix;
            cnt      <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            lockup_q <= seed_in == '0;
            mode_q   <= mode;
        end else begin
            mode_q   <= mode;
            ref_q    <= ref_eff;
            repeat_q <= enable && hit;
            lockup_q <= enable && zero;
            if (enable) begin
                state <= nxt;
                cnt   <= hit ? '0 : cnt_inc;
                if (hit) begin
                    period_q <= cnt_inc;
                    valid_q  <= 1'b1;
                end
            end else begin
                cnt <= cnt_base;
            end
        end
    end

    assign seed_out     = state;
    assign lockup       = lockup_q;
    assign repeat_found = repeat_q;
    assign period       = period_q;
    assign period_valid = valid_q;
endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: directed vector table plus multi-cycle period/lockup/mode sequences
module tb_lfsr_prng;
    logic        clk = 1'b0;
    logic        rst8, ld8, en8, md8;
    logic [7:0]  seed8, so8;
    logic        lk8, rf8, pv8;
    logic [63:0] per8;
    logic        rst16, ld16, en16, md16;
    logic [15:0] seed16, so16;
    logic        lk16, rf16, pv16;
    logic [63:0] per16;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    lfsr_prng #(.WIDTH(8)) d8 (
        .clk(clk), .reset(rst8), .seed_in(seed8), .load(ld8), .enable(en8), .mode(md8),
        .seed_out(so8), .lockup(lk8), .repeat_found(rf8), .period(per8), .period_valid(pv8)
    );

    lfsr_prng #(.WIDTH(16)) d16 (
        .clk(clk), .reset(rst16), .seed_in(seed16), .load(ld16), .enable(en16), .mode(md16),
        .seed_out(so16), .lockup(lk16), .repeat_found(rf16), .period(per16), .period_valid(pv16)
    );

    typedef struct {
        logic       rst, ld, en, md;
        logic [7:0] seed;
        logic [7:0] so;
        logic       lk, rf, pv;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic steps8(input int n, output int hits, output int first);
        hits = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (rf8) begin
                hits++;
                if (first == 0) first = i;
            end
        end
    endtask

    int         hits, first, bad;
    logic [7:0] snap;

    initial begin
        rst8 = 1; ld8 = 0; en8 = 0; md8 = 0; seed8 = 8'h7A;
        rst16 = 1; ld16 = 0; en16 = 0; md16 = 1; seed16 = 16'h0001;
        v[0]  = '{1, 0, 0, 0, 8'h7A, 8'h7A, 0, 0, 0};
        v[1]  = '{0, 0, 1, 0, 8'h7A, 8'hF5, 0, 0, 0};
        v[2]  = '{0, 0, 1, 0, 8'h7A, 8'hEB, 0, 0, 0};
        v[3]  = '{0, 0, 0, 0, 8'h7A, 8'hEB, 0, 0, 0};
        v[4]  = '{0, 0, 1, 0, 8'h7A, 8'hD7, 0, 0, 0};
        v[5]  = '{0, 1, 1, 0, 8'h00, 8'h01, 1, 0, 0};
        v[6]  = '{0, 0, 1, 0, 8'h00, 8'h02, 0, 0, 0};
        v[7]  = '{0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0};
        v[8]  = '{0, 1, 1, 1, 8'h80, 8'h80, 0, 0, 0};
        v[9]  = '{0, 0, 1, 1, 8'h80, 8'h71, 0, 0, 0};
        v[10] = '{0, 0, 1, 1, 8'h80, 8'hE2, 0, 0, 0};
        v[11] = '{0, 0, 1, 1, 8'h80, 8'hB5, 0, 0, 0};
        v[12] = '{0, 0, 1, 1, 8'h80, 8'h1B, 0, 0, 0};
        cyc();
        rst16 = 0;
        for (int i = 0; i < 13; i++) begin
            rst8 = v[i].rst; ld8 = v[i].ld; en8 = v[i].en; md8 = v[i].md; seed8 = v[i].seed;
            cyc();
            chk($sformatf("vec%0d seed_out", i), 64'(so8), 64'(v[i].so));
            chk($sformatf("vec%0d lockup", i), 64'(lk8), 64'(v[i].lk));
            chk($sformatf("vec%0d repeat", i), 64'(rf8), 64'(v[i].rf));
            chk($sformatf("vec%0d valid", i), 64'(pv8), 64'(v[i].pv));
            chk($sformatf("vec%0d period", i), per8, 64'd0);
        end
        ld8 = 0; en8 = 0;

        // Fibonacci full period, twice
        rst8 = 1; md8 = 0; seed8 = 8'h7A; cyc(); rst8 = 0; en8 = 1;
        for (int r = 0; r < 2; r++) begin
            steps8(255, hits, first);
            chk($sformatf("fib%0d hits", r), 64'(hits), 64'd1);
            chk($sformatf("fib%0d first", r), 64'(first), 64'd255);
            chk($sformatf("fib%0d seed", r), 64'(so8), 64'h7A);
            chk($sformatf("fib%0d period", r), per8, 64'd255);
            chk($sformatf("fib%0d valid", r), 64'(pv8), 64'd1);
        end
        cyc();
        chk("fib pulse width", 64'(rf8), 64'd0);

        // Galois full period; load clears period_valid
        en8 = 0; ld8 = 1; md8 = 1; seed8 = 8'h80; cyc(); ld8 = 0;
        chk("gal load valid", 64'(pv8), 64'd0);
        chk("gal load period", per8, 64'd0);
        en8 = 1;
        steps8(255, hits, first);
        chk("gal hits", 64'(hits), 64'd1);
        chk("gal first", 64'(first), 64'd255);
        chk("gal seed", 64'(so8), 64'h80);
        chk("gal period", per8, 64'd255);

        // Freeze with enable low
        en8 = 0; rst8 = 1; md8 = 0; seed8 = 8'h7A; cyc(); rst8 = 0; en8 = 1;
        steps8(100, hits, first);
        chk("frz pre hits", 64'(hits), 64'd0);
        snap = so8;
        en8 = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (so8 !== snap || rf8 !== 1'b0) bad++;
        end
        chk("frz hold", 64'(bad), 64'd0);
        en8 = 1;
        steps8(155, hits, first);
        chk("frz hits", 64'(hits), 64'd1);
        chk("frz first", 64'(first), 64'd155);
        chk("frz seed", 64'(so8), 64'h7A);
        chk("frz period", per8, 64'd255);

        // Mode flip together with a step re-anchors on the pre-step state
        en8 = 0; rst8 = 1; md8 = 0; cyc(); rst8 = 0; en8 = 1;
        steps8(50, hits, first);
        snap = so8;
        md8 = 1;
        steps8(255, hits, first);
        chk("mode hits", 64'(hits), 64'd1);
        chk("mode first", 64'(first), 64'd255);
        chk("mode seed", 64'(so8), 64'(snap));
        chk("mode period", per8, 64'd255);
        chk("mode valid", 64'(pv8), 64'd1);
        steps8(20, hits, first);
        rst8 = 1; md8 = 0; seed8 = 8'h7A; cyc(); rst8 = 0; en8 = 0;
        chk("midrst seed", 64'(so8), 64'h7A);
        chk("midrst valid", 64'(pv8), 64'd0);
        chk("midrst period", per8, 64'd0);
        chk("midrst repeat", 64'(rf8), 64'd0);

        // 16-bit Galois full period
        en16 = 1; hits = 0; first = 0;
        for (int i = 1; i <= 65535; i++) begin
            cyc();
            if (rf16) begin
                hits++;
                if (first == 0) first = i;
            end
        end
        chk("w16 hits", 64'(hits), 64'd1);
        chk("w16 first", 64'(first), 64'd65535);
        chk("w16 seed", 64'(so16), 64'h1);
        chk("w16 period", per16, 64'hFFFF);
        chk("w16 valid", 64'(pv16), 64'd1);
        chk("w16 lockup", 64'(lk16), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised maximal-length LFSR pseudo-random generator. Successor to the fixed 64-bit lfsr64.
- Adds configurable width and polynomial, runtime Fibonacci/Galois mode, step enable and seed load.
- Adds all-zero lockup recovery and built-in period measurement, so maximal-length checks run in hardware rather than in a bench.
- Sits wherever the design needs a seeded PRNG stream (test-pattern generation, scrambling).

Parameters:
- WIDTH, 64, state width; legal range 4..64.
- TAPS, 0, tap mask with bit i-1 set for polynomial term x^i (bit WIDTH-1 must be set). 0 selects the built-in table: 8 → 0xB8; 16 → 0xD008; 32 → 0x80200003; 64 → 0xD800000000000000. TAPS=0 with any other WIDTH is an elaboration error.
- CNT_W, 64, width of the step counter and period register.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- seed_in  in  WIDTH  seed value used on reset or load
- load  in  1  load seed_in on this edge
- enable  in  1  advance one LFSR step on this edge
- mode  in  1  0 = Fibonacci, 1 = Galois
- seed_out  out  WIDTH  current LFSR state
- lockup  out  1  one-cycle pulse: an all-zero state was replaced by 1
- repeat_found  out  1  one-cycle pulse: state returned to the reference value
- period  out  CNT_W  steps between the two most recent reference hits
- period_valid  out  1  sticky; set on first repeat_found, cleared by reset or load

Behaviour:
- One clock domain, synchronous reset. Priority each edge: reset > load > enable step > hold.
- Reset or load:
  - seed_out ← seed_in; if seed_in == 0, seed_out ← 1 and lockup pulses the next cycle.
  - Reference register ← the loaded value; step counter ← 0; period ← 0; period_valid ← 0; repeat_found ← 0.
  - Reset mid-operation abandons any measurement in progress.
- Let S = seed_out, M = tap mask, W = WIDTH.
- Fibonacci step: next = {S[W-2:0], ^(S & M)}.
- Galois step: next = {S[W-2:0], 0} XOR (S[W-1] ? {M[W-2:0], 1} : 0).
- Lockup: if enable and S == 0 (unreachable except through a corrupted state), next = 1 and lockup pulses. The step still counts.
- Step counter:
  - Increments by 1 on each enabled step; saturates at all-ones and never wraps.
  - If next == reference on a step: period ← counter+1; repeat_found = 1 for exactly one cycle (registered, aligned with seed_out == reference); period_valid ← 1; counter ← 0. The generator keeps running.
- Mode change: mode is sampled every cycle against a registered copy. On any change without reset/load, reference ← current S and counter ← 0. period and period_valid hold until the next repeat.
  - A step in the same cycle uses the new mode, and the reference is the pre-step S.
- enable low: seed_out, counter, reference and all flags hold; pulses deassert.
- load and enable together: load wins and no step is taken.
- Latency: one cycle from enable to new seed_out; repeat_found coincides with the seed_out that equals the reference.
- Reset values: seed_out = seed_in (or 1 if seed_in is 0); lockup, repeat_found, period_valid = 0; period = 0.

Test Plan:
1. WIDTH=8, TAPS=0, mode=0, reset with seed_in=0x7A, enable=1 → first step 0xF5. repeat_found pulses after exactly 255 steps, period=255, period_valid=1. Second pulse 255 steps later.
2. WIDTH=8, mode=1, seed_in=0x80 → first step 0x71. Period = 255.
3. WIDTH=16, mode=1, seed_in=0x0001 → repeat_found after 65535 steps, period=0xFFFF. No repeat_found at any earlier step.
4. Load seed_in=0 → seed_out=1, lockup high for one cycle. Load and enable asserted together → no step taken.
5. WIDTH=8, mode=0, seed 0x7A, 100 steps, then enable low for 10 cycles → seed_out and counter frozen. Re-enable → repeat_found at total 255 steps.
6. WIDTH=8, seed 0x7A, 50 steps, then flip mode → counter cleared, reference = current state. repeat_found 255 steps later. Reset asserted mid-run clears period_valid and reloads 0x7A.
